data_mem_wait_ctrl: RTL

//  Wait-state controller between the CPU data port (MemRead/MemWrite, address_data,

---
 rtl/data_mem_wait_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/data_mem_wait_ctrl.sv
// Purpose : wait-state controller between the CPU data port and dataMemory.
// Latency : WAIT_CYCLES+2 cycles after the request cycle for good accesses, 1 for misaligned ones.
// Backpr. : CPU holds cpu_read/cpu_write until the one-cycle cpu_ready pulse; no re-accept in DONE/ERR.
//
// Ports:
//   clk, reset                  clock and asynchronous active-low reset
//   cpu_read/cpu_write          request strobes (write wins when both are high)
//   cpu_addr/cpu_wdata          request byte address and write data
//   cpu_rdata                   last completed read data (held across writes and errors)
//   cpu_ready/cpu_err           one-cycle completion pulse; err flags a misaligned request
//   busy                        high whenever the FSM is not idle
//   mem_read/mem_write          dataMemory strobes (exactly one write cycle per write)
//   mem_addr/mem_wdata          latched request address and data
//   mem_rdata                   dataMemory read data
//   access_count                completed good accesses, wraps
module data_mem_wait_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  access_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

    state_t            state;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_wr;   // 1 = write, 0 = read

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_wr       <= 1'b0;
            cpu_rdata    <= '0;
            access_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_read || cpu_write) begin
                        lat_addr  <= cpu_addr;
                        lat_wdata <= cpu_wdata;
                        lat_wr    <= cpu_write;
                        // Only the low two address bits decide word alignment.
                        if (cpu_addr[1:0] != 2'b00) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state        <= S_DONE;
                        access_count <= access_count + CNT_W'(1);
                        if (!lat_wr) begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from registered state so a reset drops them at once.
    assign busy      = (state != S_IDLE);
    assign cpu_ready = (state == S_DONE) || (state == S_ERR);
    assign cpu_err   = (state == S_ERR);
    assign mem_read  = (state == S_WAIT) && !lat_wr;
    // Write strobe only in the final wait cycle so memory sees a single write.
    assign mem_write = (state == S_WAIT) && lat_wr && (cnt == 8'd0);
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule
